// File: rtl/axi_rw_bridge.sv
// Bridges the single-beat ram_rw request port onto AXI4 as one single-beat read or write per request.
// Latency 3 cycles minimum from capture to rw_ready_o; AXI valids/readies are registered and held until handshake.
module axi_rw_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rw_cen_i,
    input  logic        rw_wen_i,
    input  logic [63:0] rw_addr_i,
    input  logic [63:0] rw_wdata_i,
    input  logic [7:0]  rw_wmask_i,
    input  logic [2:0]  rw_size_i,
    output logic        rw_ready_o,
    output logic [63:0] rw_data_o,
    output logic        rw_err_o,
    output logic        aw_valid_o,
    input  logic        aw_ready_i,
    output logic [63:0] aw_addr_o,
    output logic [3:0]  aw_id_o,
    output logic [7:0]  aw_len_o,
    output logic [2:0]  aw_size_o,
    output logic [1:0]  aw_burst_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic [63:0] w_data_o,
    output logic [7:0]  w_strb_o,
    output logic        w_last_o,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [1:0]  b_resp_i,
    output logic        ar_valid_o,
    input  logic        ar_ready_i,
    output logic [63:0] ar_addr_o,
    output logic [3:0]  ar_id_o,
    output logic [7:0]  ar_len_o,
    output logic [2:0]  ar_size_o,
    output logic [1:0]  ar_burst_o,
    input  logic        r_valid_i,
    output logic        r_ready_o,
    input  logic [63:0] r_data_i,
    input  logic [1:0]  r_resp_i,
    input  logic        r_last_i
);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, DONE} state_t;

    state_t      state_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  strb_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [3:0]  id_q;
    logic        aw_valid_q;
    logic        w_valid_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        b_ready_q;
    logic        ar_valid_q;
    logic        r_ready_q;
    logic        rw_ready_q;
    logic        rw_err_q;
    logic [63:0] rw_data_q;

    logic [7:0]  strb_d;
    logic        aw_done_d;
    logic        w_done_d;

    // A zero mask means the arbiter wants the natural strobe for the access size.
    always_comb begin
        strb_d = rw_wmask_i;
        if (rw_wmask_i == 8'd0) begin
            case (rw_size_i)
                3'd0:    strb_d = 8'h01 << rw_addr_i[2:0];
                3'd1:    strb_d = 8'h03 << rw_addr_i[2:0];
                3'd2:    strb_d = 8'h0F << rw_addr_i[2:0];
                default: strb_d = 8'hFF << rw_addr_i[2:0];
            endcase
        end
    end

    assign aw_done_d = aw_done_q | (aw_valid_q & aw_ready_i);
    assign w_done_d  = w_done_q  | (w_valid_q  & w_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            strb_q     <= 8'd0;
            size_q     <= 3'd0;
            burst_q    <= 2'b00;
            id_q       <= 4'd0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            rw_ready_q <= 1'b0;
            rw_err_q   <= 1'b0;
            rw_data_q  <= 64'd0;
        end else begin
            rw_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rw_cen_i) begin
                        addr_q  <= rw_addr_i;
                        wdata_q <= rw_wdata_i;
                        strb_q  <= strb_d;
                        size_q  <= rw_size_i;
                        burst_q <= 2'b01;
                        id_q    <= AXI_ID;
                        if (rw_wen_i) begin
                            state_q    <= WR;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                        end else begin
                            state_q    <= RA;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_valid_q && aw_ready_i) aw_valid_q <= 1'b0;
                    if (w_valid_q && w_ready_i)   w_valid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        state_q   <= WB;
                        b_ready_q <= 1'b1;
                    end
                end
                WB: begin
                    if (b_valid_i) begin
                        b_ready_q  <= 1'b0;
                        rw_err_q   <= (b_resp_i != 2'b00);
                        rw_ready_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                RA: begin
                    if (ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD;
                    end
                end
                RD: begin
                    if (r_valid_i) begin
                        r_ready_q  <= 1'b0;
                        rw_data_q  <= r_data_i;
                        rw_err_q   <= (r_resp_i != 2'b00);
                        rw_ready_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                // Completion cycle: the arbiter may still hold cen, so never capture here.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Single-beat bridge: RLAST carries no information.
    logic unused_rlast;
    assign unused_rlast = r_last_i;

    assign rw_ready_o = rw_ready_q;
    assign rw_data_o  = rw_data_q;
    assign rw_err_o   = rw_err_q;

    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = id_q;
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = size_q;
    assign aw_burst_o = burst_q;

    assign w_valid_o  = w_valid_q;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = strb_q;
    assign w_last_o   = w_valid_q;

    assign b_ready_o  = b_ready_q;

    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = addr_q;
    assign ar_id_o    = id_q;
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = size_q;
    assign ar_burst_o = burst_q;

    assign r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Directed bench for axi_rw_bridge: a cycle-window model of each transaction is checked every cycle.
module tb_axi_rw_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rw_cen_i, rw_wen_i;
    logic [63:0] rw_addr_i, rw_wdata_i;
    logic [7:0]  rw_wmask_i;
    logic [2:0]  rw_size_i;
    logic        rw_ready_o, rw_err_o;
    logic [63:0] rw_data_o;
    logic        aw_valid_o, aw_ready_i;
    logic [63:0] aw_addr_o;
    logic [3:0]  aw_id_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic        w_valid_o, w_ready_i, w_last_o;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        b_valid_i, b_ready_o;
    logic [1:0]  b_resp_i;
    logic        ar_valid_o, ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [3:0]  ar_id_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        r_valid_i, r_ready_o, r_last_i;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;

    axi_rw_bridge #(.AXI_ID(4'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .rw_cen_i(rw_cen_i), .rw_wen_i(rw_wen_i), .rw_addr_i(rw_addr_i),
        .rw_wdata_i(rw_wdata_i), .rw_wmask_i(rw_wmask_i), .rw_size_i(rw_size_i),
        .rw_ready_o(rw_ready_o), .rw_data_o(rw_data_o), .rw_err_o(rw_err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the transaction in flight: cycle t counts from the capture edge (t=0 is the IDLE cycle).
    logic        act = 1'b0;
    logic        cmp_en = 1'b0;
    int          t = 0;
    logic        m_wr;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_strb;
    logic [2:0]  m_size;
    logic [1:0]  m_resp;
    int          m_aw_hs, m_w_hs, m_ar_hs, m_from, m_wb, m_bhs, m_rd, m_rhs, m_done;
    logic [63:0] last_rdata = 64'd0;

    int          ready_t, first_b;
    logic        err_seen;
    logic [7:0]  strb_seen;

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", name, act_v, exp_v, t, $time);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] model_strb(input logic [7:0] wm, input logic [2:0] sz, input logic [63:0] a);
        int nbytes;
        logic [15:0] m;
        if (wm != 8'd0) return wm;
        nbytes = 1 << sz;
        m = 16'((1 << nbytes) - 1) << a[2:0];
        return m[7:0];
    endfunction

    task automatic drive_slave();
        aw_ready_i = m_wr && (t == m_aw_hs);
        w_ready_i  = m_wr && (t == m_w_hs);
        ar_ready_i = !m_wr && (t == m_ar_hs);
        b_valid_i  = m_wr && (t >= m_from) && (t <= m_bhs);
        b_resp_i   = m_resp;
        r_valid_i  = !m_wr && (t >= m_from) && (t <= m_rhs);
        r_data_i   = r_valid_i ? m_rdata : 64'hBAD0_BAD0_BAD0_BAD0;
        r_resp_i   = m_resp;
        r_last_i   = r_valid_i;
    endtask

    task automatic slave_idle();
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 0;
    endtask

    // hs_a: AW (write) or AR (read) handshake cycle; from: first cycle B/R valid is offered.
    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, input logic [2:0] size, input int hs_a,
                           input int hs_w, input int from, input logic [1:0] resp,
                           input logic [63:0] rdata, input logic keep, input int abort_t);
        @(posedge clk); #1;
        m_wr = wr; m_addr = addr; m_wdata = wdata; m_size = size; m_resp = resp; m_rdata = rdata;
        m_strb = model_strb(wmask, size, addr);
        m_aw_hs = hs_a; m_w_hs = hs_w; m_ar_hs = hs_a; m_from = from;
        m_wb = imax(hs_a, hs_w) + 1; m_bhs = imax(m_wb, from);
        m_rd = hs_a + 1; m_rhs = imax(m_rd, from);
        m_done = wr ? m_bhs + 1 : m_rhs + 1;
        ready_t = -1; first_b = -1; err_seen = 0; strb_seen = 0;
        rw_cen_i = 1; rw_wen_i = wr; rw_addr_i = addr; rw_wdata_i = wdata;
        rw_wmask_i = wmask; rw_size_i = size;
        t = 0; act = 1;
        drive_slave();
        while (t < m_done) begin
            @(posedge clk); #1;
            t++;
            if (abort_t != 0 && t == abort_t) begin
                chk("pre_rst_bready", b_ready_o, 1);
                #1;
                cmp_en = 0;
                rst_n = 0;
                #1;
                chk("async_rst_ctrl", {aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, rw_ready_o}, 0);
                rw_cen_i = 0; act = 0; slave_idle();
                last_rdata = 64'd0;
                @(posedge clk); #1;
                chk("rst_held_ready", rw_ready_o, 0);
                rst_n = 1;
                cmp_en = 1;
                return;
            end
            rw_addr_i = ~addr; rw_wdata_i = ~wdata; rw_wmask_i = ~wmask; rw_size_i = ~size;
            drive_slave();
        end
        @(negedge clk); #1;
        if (!wr) last_rdata = rdata;
        act = 0;
        if (!keep) rw_cen_i = 0;
        slave_idle();
    endtask

    logic e_awv, e_wv, e_br, e_arv, e_rr, e_rdy;
    logic [63:0] e_rdata;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_awv = act && m_wr && t >= 1 && t <= m_aw_hs;
            e_wv  = act && m_wr && t >= 1 && t <= m_w_hs;
            e_br  = act && m_wr && t >= m_wb && t <= m_bhs;
            e_arv = act && !m_wr && t >= 1 && t <= m_ar_hs;
            e_rr  = act && !m_wr && t >= m_rd && t <= m_rhs;
            e_rdy = act && t == m_done;
            e_rdata = (act && !m_wr && t >= m_done) ? m_rdata : last_rdata;
            chk("aw_valid", aw_valid_o, e_awv);
            chk("w_valid", {w_valid_o, w_last_o}, {e_wv, e_wv});
            chk("b_ready", b_ready_o, e_br);
            chk("ar_valid", ar_valid_o, e_arv);
            chk("r_ready", r_ready_o, e_rr);
            chk("rw_ready", rw_ready_o, e_rdy);
            chk("rw_data", rw_data_o, e_rdata);
            if (e_awv) begin
                chk("aw_addr", aw_addr_o, m_addr);
                chk("aw_fields", {aw_size_o, aw_len_o, aw_burst_o, aw_id_o}, {m_size, 8'd0, 2'b01, 4'd0});
            end
            if (e_wv) begin
                chk("w_data", w_data_o, m_wdata);
                chk("w_strb", w_strb_o, m_strb);
                strb_seen = w_strb_o;
            end
            if (e_arv) begin
                chk("ar_addr", ar_addr_o, m_addr);
                chk("ar_fields", {ar_size_o, ar_len_o, ar_burst_o, ar_id_o}, {m_size, 8'd0, 2'b01, 4'd0});
            end
            if (e_rdy) chk("rw_err", rw_err_o, m_resp != 2'b00);
            if (rw_ready_o && ready_t < 0) begin ready_t = t; err_seen = rw_err_o; end
            if (b_ready_o && first_b < 0) first_b = t;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        rw_cen_i = 0; rw_wen_i = 0; rw_addr_i = 0; rw_wdata_i = 0; rw_wmask_i = 0; rw_size_i = 0;
        m_wr = 0; m_aw_hs = 0; m_w_hs = 0; m_ar_hs = 0; m_from = 0; m_bhs = 0; m_rhs = 0;
        m_wb = 0; m_rd = 0; m_done = 0; m_resp = 0; m_rdata = 0; m_addr = 0; m_wdata = 0;
        m_strb = 0; m_size = 0;
        slave_idle();
        #12;
        chk("rst_ctrl", {aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, rw_ready_o}, 0);
        chk("rst_aw_addr", aw_addr_o, 0);
        chk("rst_ar_addr", ar_addr_o, 0);
        chk("rst_w_data", w_data_o, 0);
        chk("rst_rw_data", rw_data_o, 0);
        chk("rst_fields", {aw_id_o, aw_len_o, aw_burst_o, aw_size_o, ar_id_o, ar_len_o, ar_burst_o, ar_size_o}, 0);
        chk("rst_w_misc", {w_strb_o, w_last_o, rw_err_o}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        cmp_en = 1;
        repeat (2) @(posedge clk);

        // Zero-wait read.
        run_txn(0, 64'h8000_0010, 64'd0, 8'h00, 3'd3, 1, 0, 0, 2'b00, 64'h1122_3344_5566_7788, 0, 0);
        chk("rd_latency", ready_t, 3);
        chk("rd_data_lit", rw_data_o, 64'h1122_3344_5566_7788);

        // Write with strobe derived from size 1 at offset 6.
        run_txn(1, 64'h8000_0006, 64'hAABB_0000_0000_0000, 8'h00, 3'd1, 1, 1, 2, 2'b00, 64'd0, 0, 0);
        chk("wr_strb_lit", strb_seen, 8'hC0);
        chk("wr_latency", ready_t, 3);

        // AW accepted at cycle 1, W only at cycle 4.
        run_txn(1, 64'h8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F, 3'd2, 1, 4, 0, 2'b00, 64'd0, 0, 0);
        chk("split_bready_start", first_b, 5);
        chk("split_latency", ready_t, 6);

        // AR stalled 5 cycles, R 3 cycles late with SLVERR.
        run_txn(0, 64'h8000_2000, 64'd0, 8'h00, 3'd3, 6, 0, 10, 2'b10, 64'h0123_4567_89AB_CDEF, 0, 0);
        chk("stall_err", err_seen, 1);
        chk("stall_latency", ready_t, 11);

        // B offered before WB, W before AW, DECERR; byte write at offset 5.
        run_txn(1, 64'h1000_0005, 64'h0000_5500_0000_0000, 8'h00, 3'd0, 2, 1, 1, 2'b11, 64'd0, 0, 0);
        chk("early_b_strb", strb_seen, 8'h20);
        chk("early_b_err", err_seen, 1);
        chk("early_b_latency", ready_t, 4);
        chk("wr_keeps_rdata", rw_data_o, 64'h0123_4567_89AB_CDEF);

        // cen left high through DONE; the next request is only taken in IDLE.
        run_txn(0, 64'h8000_0040, 64'd0, 8'h00, 3'd3, 1, 0, 0, 2'b00, 64'hCAFE_F00D_1234_5678, 1, 0);
        run_txn(1, 64'h8000_0048, 64'h0000_0000_0000_1111, 8'hFF, 3'd3, 1, 1, 0, 2'b00, 64'd0, 0, 0);
        chk("b2b_latency", ready_t, 3);

        // Reset while waiting in WB.
        run_txn(1, 64'h8000_0080, 64'h0000_0000_0000_2222, 8'h00, 3'd3, 1, 1, 20, 2'b00, 64'd0, 0, 3);
        chk("post_rst_rdata", rw_data_o, 64'd0);
        repeat (2) @(posedge clk);

        // Read after reset proves the FSM came back to IDLE.
        run_txn(0, 64'h8000_0008, 64'd0, 8'h00, 3'd2, 2, 0, 0, 2'b01, 64'h0000_0000_7654_3210, 0, 0);
        chk("post_rst_latency", ready_t, 4);
        chk("post_rst_err", err_seen, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rw_bridge.md
# axi_rw_bridge

Converts the single-beat RAM request port driven by `ram_arbiter` (`ram_rw_*`) into AXI4 master transactions and returns completion and read data to the arbiter. It sits directly downstream of the arbiter and is the core's only path to the SoC bus. Each accepted request produces exactly one single-beat AXI read or write. Completion is reported with a one-cycle `rw_ready_o` pulse.

## Interface
- `AXI_ID`, default 4'd0: constant value driven on `aw_id_o` / `ar_id_o`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rw_cen_i` in 1: request valid. The arbiter holds it, with the fields below stable, until `rw_ready_o`.
- `rw_wen_i` in 1: 1 = write, 0 = read.
- `rw_addr_i` in 64: byte address, forwarded unmodified.
- `rw_wdata_i` in 64: write data, already lane-aligned.
- `rw_wmask_i` in 8: byte strobe. 0 means derive the strobe from size.
- `rw_size_i` in 3: AXI size encoding (0 = 1 B … 3 = 8 B).
- `rw_ready_o` out 1: one-cycle completion pulse.
- `rw_data_o` out 64: read data, raw bus lanes.
- `rw_err_o` out 1: valid with `rw_ready_o`. It is 1 if the response was non-OKAY.
- `aw_valid_o` out 1, `aw_ready_i` in 1, `aw_addr_o` out 64, `aw_id_o` out 4, `aw_len_o` out 8, `aw_size_o` out 3, `aw_burst_o` out 2.
- `w_valid_o` out 1, `w_ready_i` in 1, `w_data_o` out 64, `w_strb_o` out 8, `w_last_o` out 1.
- `b_valid_i` in 1, `b_ready_o` out 1, `b_resp_i` in 2.
- `ar_valid_o` out 1, `ar_ready_i` in 1, `ar_addr_o` out 64, `ar_id_o` out 4, `ar_len_o` out 8, `ar_size_o` out 3, `ar_burst_o` out 2.
- `r_valid_i` in 1, `r_ready_o` out 1, `r_data_i` in 64, `r_resp_i` in 2, `r_last_i` in 1.

## Operation
- **FSM states:** IDLE, WR (AW+W), WB, RA, RD, DONE.
- **IDLE:**
  - If `rw_cen_i` = 1, capture addr/size/wdata/strobe into registers.
  - If `rw_wen_i` = 1, go to WR; otherwise go to RA.
- **Strobe:**
  - If `rw_wmask_i` ≠ 0, use it.
  - Otherwise use `({1,3,15,255}[size]) << addr[2:0]`, truncated to 8 bits.
- **WR:**
  - `aw_valid_o` and `w_valid_o` assert together and are tracked independently by `aw_done` / `w_done` flags.
  - Each valid drops on its own handshake.
  - When both flags are set, go to WB.
- **WB:** `b_ready_o` = 1. On a `b_valid_i` handshake, latch `rw_err_o` = (`b_resp_i` ≠ 0) and go to DONE.
- **RA:** `ar_valid_o` = 1. On `ar_ready_i`, go to RD.
- **RD:** `r_ready_o` = 1. On a `r_valid_i` handshake, latch `rw_data_o` = `r_data_i`, set `rw_err_o` = (`r_resp_i` ≠ 0), and go to DONE. `r_last_i` is ignored; len = 0.
- **DONE:**
  - `rw_ready_o` = 1 for this cycle only.
  - `rw_cen_i` is ignored.
  - Unconditionally return to IDLE.
- **Constant AXI fields:** len = 0, burst = 2'b01 (INCR), `w_last_o` = 1 whenever `w_valid_o`, id = `AXI_ID`.
- **Holding rules:**
  - AXI address, data and strobe outputs come from the captured registers and stay stable while their valid is high.
  - A valid never drops before its handshake.
- `rw_data_o` holds its value until the next read completes. Writes leave it unchanged.
- Input changes while the FSM is not in IDLE are ignored.

## Timing
- **Reset values:** all outputs 0, including `w_last_o` and the id/len/burst/size/addr fields. The FSM resets to IDLE and the flags clear.
- **Reset mid-transaction:** all valids and readies drop immediately (asynchronous). No completion pulse is generated. The slave protocol violation this causes is accepted; reset is system-wide.
- **Valid timing:** AW, W and AR valids assert on the cycle after the IDLE capture edge. They are registered; there is no combinational path from `rw_*` to the AXI outputs.
- **Minimum latency, read, zero-wait slave:**
  - Capture edge 0.
  - `ar_valid` in cycle 1, handshake in cycle 1.
  - `r_ready` in cycle 2, handshake in cycle 2.
  - `rw_ready_o` in cycle 3.
- **Minimum latency, write:** AW/W handshake in cycle 1, B in cycle 2, `rw_ready_o` in cycle 3.
- **AW/W ordering:** AW and W may complete in either order or the same cycle. WB is entered the cycle after the later of the two.
- **B/R accepted early:** `b_valid_i` / `r_valid_i` that arrive before the FSM reaches WB/RD are not accepted; `b_ready_o` / `r_ready_o` are low in those cycles.
- **Back-to-back requests:** the earliest a new request can be captured is the cycle after DONE, so throughput is at most one transaction per 4 cycles.

## Test plan
- **Read, zero wait:** cen=1, wen=0, addr=0x8000_0010, size=3; `r_data`=0x1122_3344_5566_7788 -> `ar_addr`=0x8000_0010, `ar_size`=3, `ar_len`=0; one `rw_ready_o` pulse in cycle 3; `rw_data_o`=0x1122_3344_5566_7788; `rw_err_o`=0.
- **Write, derived strobe:** wen=1, addr=0x8000_0006, size=1, wmask=0 -> `w_strb`=0xC0, `w_last`=1; `rw_ready_o` follows the B handshake by 1 cycle.
- **Split AW/W handshake:** `aw_ready` at cycle 1, `w_ready` delayed to cycle 4 -> `aw_valid` low from cycle 2, `w_valid` held to cycle 4, `b_ready` from cycle 5, exactly one completion.
- **Slave stalls:** `ar_ready` low 5 cycles, then `r_valid` delayed 3 cycles with `r_resp`=2'b10 -> `ar_addr` stable throughout, `rw_err_o`=1 with the ready pulse, no duplicate AR.
- **cen held after ready:** `rw_cen_i` kept high 1 cycle past `rw_ready_o` -> no new transaction issued from DONE; a second transaction starts only if cen is still high in IDLE.
- **Reset mid-write:** assert `rst_n`=0 during WB -> all AXI valids and readies go 0 asynchronously, `rw_ready_o`=0, FSM in IDLE after release.
